// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared types and constants for the CPU fetch path            |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int ADDR_W      = 8;
  localparam int OPC_IMM_BIT = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OP  = 2'd1,
    WAIT_IMM = 2'd2,
    DONE     = 2'd3
  } fetch_state_t;

  // Opcodes with the top bit set carry one immediate byte after them.
  function automatic logic has_imm(input logic [ADDR_W-1:0] opc);
    return opc[OPC_IMM_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_timer: counts stalled memory-wait cycles, flags expiry          |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Expiry fires on the stalled cycle that would make the count reach the limit.
  assign o_expired = i_en && (r_count == 8'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch: fetches a 1- or 2-byte instruction from memory           |
// | Optional read timeout when FETCH_TIMEOUT_EN is defined.               |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk_fetch,
  input  logic              rst_fetch,
  input  logic [ADDR_W-1:0] addr_PC,
  input  logic              fetch_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              write_pc,
  output logic [ADDR_W-1:0] ir_out,
  output logic [ADDR_W-1:0] operand_out,
  output logic              fetch_done,
  output logic              fetch_err
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_operand;
  logic              r_write_pc;
  logic              r_fetch_done;
  logic              w_waiting;
  logic              w_timeout;

  assign w_waiting = (r_state == WAIT_OP) || (r_state == WAIT_IMM);

`ifdef FETCH_TIMEOUT_EN
  logic r_fetch_err;

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fetch_timer (
    .clk       (clk_fetch),
    .rst       (rst_fetch),
    .i_clr     (r_state != w_state_next),
    .i_en      (w_waiting && !mem_ready),
    .o_expired (w_timeout)
  );

  always_ff @(posedge clk_fetch) begin
    if (rst_fetch) begin
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_err <= w_timeout;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^8'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign fetch_err        = 1'b0;
`endif

  always_ff @(posedge clk_fetch) begin
    if (rst_fetch) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (fetch_req) w_state_next = WAIT_OP;
      end
      WAIT_OP: begin
        if (mem_ready)      w_state_next = has_imm(mem_rdata) ? WAIT_IMM : DONE;
        else if (w_timeout) w_state_next = IDLE;
      end
      WAIT_IMM: begin
        if (mem_ready)      w_state_next = DONE;
        else if (w_timeout) w_state_next = IDLE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_rd = w_waiting;
  end

  // Datapath registers; pulses default low and are raised only by the state that owns them.
  always_ff @(posedge clk_fetch) begin
    if (rst_fetch) begin
      r_mem_addr   <= '0;
      r_ir         <= '0;
      r_operand    <= '0;
      r_write_pc   <= 1'b0;
      r_fetch_done <= 1'b0;
    end else begin
      r_write_pc   <= 1'b0;
      r_fetch_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (fetch_req) r_mem_addr <= addr_PC;
        end
        WAIT_OP: begin
          if (mem_ready) begin
            r_ir       <= mem_rdata;
            r_write_pc <= 1'b1;
            if (has_imm(mem_rdata)) r_mem_addr <= r_mem_addr + ADDR_W'(1);
          end
        end
        WAIT_IMM: begin
          if (mem_ready) begin
            r_operand  <= mem_rdata;
            r_write_pc <= 1'b1;
          end
        end
        DONE:    r_fetch_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_addr    = r_mem_addr;
  assign ir_out      = r_ir;
  assign operand_out = r_operand;
  assign write_pc    = r_write_pc;
  assign fetch_done  = r_fetch_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch: scoreboard bench for instr_fetch                      |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_instr_fetch;

  typedef struct packed {
    logic [2:0] flags;
    logic [7:0] ir;
    logic [7:0] op;
    logic [7:0] addr;
  } ev_t;

  localparam logic [2:0] EV_WPC  = 3'b100;
  localparam logic [2:0] EV_DONE = 3'b010;
  localparam logic [2:0] EV_ERR  = 3'b001;

  logic       clk_fetch = 1'b0;
  logic       rst_fetch = 1'b1;
  logic [7:0] addr_PC   = 8'd0;
  logic       fetch_req = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_rdata;
  logic       write_pc;
  logic [7:0] ir_out;
  logic [7:0] operand_out;
  logic       fetch_done;
  logic       fetch_err;

  logic [7:0] mem [256];
  ev_t        exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cnt_wpc  = 0;
  int         cnt_done = 0;
  int         cnt_err  = 0;

  assign mem_rdata = mem[mem_addr];

  instr_fetch #(
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk_fetch   (clk_fetch),
    .rst_fetch   (rst_fetch),
    .addr_PC     (addr_PC),
    .fetch_req   (fetch_req),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .write_pc    (write_pc),
    .ir_out      (ir_out),
    .operand_out (operand_out),
    .fetch_done  (fetch_done),
    .fetch_err   (fetch_err)
  );

  always #5 clk_fetch = ~clk_fetch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] f, input logic [7:0] ir, input logic [7:0] op,
                      input logic [7:0] addr);
    ev_t e;
    e.flags = f;
    e.ir    = ir;
    e.op    = op;
    e.addr  = addr;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_fetch);
    #1;
  endtask

  task automatic run_fetch(input logic [7:0] pc, output int lat);
    addr_PC   = pc;
    fetch_req = 1'b1;
    @(posedge clk_fetch);
    #1;
    fetch_req = 1'b0;
    check("accept_addr", mem_addr, pc);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk_fetch);
      #1;
      lat++;
      if (fetch_done === 1'b1 || fetch_err === 1'b1) break;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, mem_addr, 8'h00);
    check({tag, "_rd"},   mem_rd, 1'b0);
    check({tag, "_wpc"},  write_pc, 1'b0);
    check({tag, "_ir"},   ir_out, 8'h00);
    check({tag, "_op"},   operand_out, 8'h00);
    check({tag, "_done"}, fetch_done, 1'b0);
    check({tag, "_err"},  fetch_err, 1'b0);
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk_fetch) begin
    ev_t e;
    if (write_pc === 1'b1)   cnt_wpc++;
    if (fetch_done === 1'b1) cnt_done++;
    if (fetch_err === 1'b1)  cnt_err++;
    if (write_pc === 1'b1 || fetch_done === 1'b1 || fetch_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got flags %b ir %h op %h addr %h, none expected",
                 {write_pc, fetch_done, fetch_err}, ir_out, operand_out, mem_addr);
      end else begin
        e = exp_q.pop_front();
        check("event", {5'd0, write_pc, fetch_done, fetch_err, ir_out, operand_out, mem_addr},
              {5'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int w0;
    int d0;
    int e0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[101]   = 8'h15;
    mem[8'hFF] = 8'h8A;
    mem[8'h00] = 8'h3C;
    mem[8'h40] = 8'h21;
    mem[8'h61] = 8'h92;
    mem[8'h62] = 8'h44;

    // Reset state
    cycles(3);
    check_all_zero("reset");
    rst_fetch = 1'b0;
    cycles(1);

    // 1-byte fetch at 101
    mem_ready = 1'b1;
    w0 = cnt_wpc;
    push(EV_WPC,  8'h15, 8'h00, 8'd101);
    push(EV_DONE, 8'h15, 8'h00, 8'd101);
    run_fetch(8'd101, lat);
    check("t1_latency", lat, 2);
    cycles(2);
    check("t1_wpc_count", cnt_wpc - w0, 1);
    check("t1_addr", mem_addr, 8'd101);

    // 2-byte fetch with address wrap FF -> 00
    w0 = cnt_wpc;
    push(EV_WPC,  8'h8A, 8'h00, 8'h00);
    push(EV_WPC,  8'h8A, 8'h3C, 8'h00);
    push(EV_DONE, 8'h8A, 8'h3C, 8'h00);
    run_fetch(8'hFF, lat);
    check("t2_latency", lat, 3);
    cycles(2);
    check("t2_wpc_count", cnt_wpc - w0, 2);
    check("t2_operand", operand_out, 8'h3C);
    check("t2_addr", mem_addr, 8'h00);

    // Stall five cycles in WAIT_OP while addr_PC moves
    mem_ready = 1'b0;
    push(EV_WPC,  8'h21, 8'h3C, 8'h40);
    push(EV_DONE, 8'h21, 8'h3C, 8'h40);
    addr_PC   = 8'h40;
    fetch_req = 1'b1;
    cycles(1);
    fetch_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr_PC = 8'h41 + 8'(i);
      cycles(1);
      check("stall_addr", mem_addr, 8'h40);
      check("stall_rd", mem_rd, 1'b1);
    end
    mem_ready = 1'b1;
    cycles(1);
    check("stall_release_wpc", write_pc, 1'b1);
    cycles(1);
    check("stall_done", fetch_done, 1'b1);
    check("stall_operand_kept", operand_out, 8'h3C);
    cycles(2);

    // fetch_req held high: three back-to-back 2-byte fetches
    addr_PC = 8'h61;
    push(EV_WPC,  8'h92, 8'h3C, 8'h62);
    push(EV_WPC,  8'h92, 8'h44, 8'h62);
    push(EV_DONE, 8'h92, 8'h44, 8'h62);
    for (int k = 0; k < 2; k++) begin
      push(EV_WPC,  8'h92, 8'h44, 8'h62);
      push(EV_WPC,  8'h92, 8'h44, 8'h62);
      push(EV_DONE, 8'h92, 8'h44, 8'h62);
    end
    w0 = cnt_wpc;
    d0 = cnt_done;
    fetch_req = 1'b1;
    cycles(9);
    fetch_req = 1'b0;
    cycles(5);
    check("b2b_wpc_count", cnt_wpc - w0, 6);
    check("b2b_done_count", cnt_done - d0, 3);

    // Reset while in WAIT_IMM with mem_ready high
    w0 = cnt_wpc;
    d0 = cnt_done;
    push(EV_WPC, 8'h92, 8'h44, 8'h62);
    addr_PC   = 8'h61;
    fetch_req = 1'b1;
    cycles(1);
    fetch_req = 1'b0;
    cycles(1);
    rst_fetch = 1'b1;
    cycles(1);
    check_all_zero("midrst");
    rst_fetch = 1'b0;
    cycles(3);
    check("midrst_wpc_count", cnt_wpc - w0, 1);
    check("midrst_done_count", cnt_done - d0, 0);
    check("midrst_idle_rd", mem_rd, 1'b0);

    // Memory never ready
    mem_ready = 1'b0;
    d0 = cnt_done;
    e0 = cnt_err;
`ifdef FETCH_TIMEOUT_EN
    push(EV_ERR, 8'h00, 8'h00, 8'h40);
    run_fetch(8'h40, lat);
    check("timeout_latency", lat, 15);
    cycles(1);
    check("timeout_idle_rd", mem_rd, 1'b0);
    check("timeout_err_pulse", fetch_err, 1'b0);
    cycles(2);
    check("timeout_err_count", cnt_err - e0, 1);
    check("timeout_no_done", cnt_done - d0, 0);
`else
    addr_PC   = 8'h40;
    fetch_req = 1'b1;
    cycles(1);
    fetch_req = 1'b0;
    cycles(100);
    check("nowait_rd", mem_rd, 1'b1);
    check("nowait_addr", mem_addr, 8'h40);
    check("nowait_err_count", cnt_err - e0, 0);
    check("nowait_no_done", cnt_done - d0, 0);
    push(EV_WPC,  8'h21, 8'h00, 8'h40);
    push(EV_DONE, 8'h21, 8'h00, 8'h40);
    mem_ready = 1'b1;
    cycles(4);
    check("nowait_done_count", cnt_done - d0, 1);
`endif

    cycles(3);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
